// File: rtl/varcic_interp.sv
// varcic_interp: variable-rate CIC interpolator for the transmit path.
// Low-rate samples are pulled through in_strobe, differentiated by a chain
// of combs, zero-stuffed to the high rate and integrated by a chain of
// accumulators clocked by out_strobe. R = INTERPOLATION x {4, 2, 1}.
//
// Handshake: in_strobe is a one-cycle pulse issued exactly once per R
// out_strobes, one clock after the wrapping out_strobe. in_data must be
// valid (show-ahead) in that cycle; it is captured at the clock edge that
// ends the pulse, and upstream advances to the next sample afterwards.
// out_strobe is a plain enable from the DUC; every out_strobe cycle
// produces one new registered out_data sample.
module varcic_interp #(
    parameter int STAGES        = 5,
    parameter int INTERPOLATION = 320,
    parameter int IN_WIDTH      = 16,
    parameter int ACC_WIDTH     = 58,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           extra_interpolation,
    input  logic                 out_strobe,
    output logic                 in_strobe,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [OUT_WIDTH-1:0] out_data
);

    // Last counter value of an R period for each rate setting.
    localparam logic [15:0] RATE_LAST_X4 = 16'(INTERPOLATION * 4 - 1);
    localparam logic [15:0] RATE_LAST_X2 = 16'(INTERPOLATION * 2 - 1);
    localparam logic [15:0] RATE_LAST_X1 = 16'(INTERPOLATION - 1);

    // Output LSB position: the gain drops by 2^(STAGES-1) per halving of R.
    localparam int LSB_X4 = ACC_WIDTH - OUT_WIDTH;
    localparam int LSB_X2 = LSB_X4 - (STAGES - 1);
    localparam int LSB_X1 = LSB_X4 - 2 * (STAGES - 1);

    // Saturation limits expressed at the width of the rounded value.
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic [1:0]           rate_sel;
    logic [15:0]          rate_last;
    logic [15:0]          sample_no;

    logic [ACC_WIDTH-1:0] comb_in   [STAGES];
    logic [ACC_WIDTH-1:0] comb_out  [STAGES];
    logic [ACC_WIDTH-1:0] comb_prev [STAGES];

    logic                 fresh;
    logic [ACC_WIDTH-1:0] stuff;
    logic [ACC_WIDTH-1:0] integ [STAGES];

    logic signed [ACC_WIDTH-1:0] acc_last;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        round_bit;
    logic signed [ACC_WIDTH:0]   rounded;
    logic [OUT_WIDTH-1:0]        out_next;

    // Fold the reserved code 11 onto x1 so the rest of the logic sees three rates.
    always_comb begin
        rate_sel = extra_interpolation;
        if (extra_interpolation == 2'b11) begin
            rate_sel = 2'b10;
        end
    end

    // Period length for the rate counter compare.
    always_comb begin
        rate_last = RATE_LAST_X1;
        case (rate_sel)
            2'b00:   rate_last = RATE_LAST_X4;
            2'b01:   rate_last = RATE_LAST_X2;
            default: rate_last = RATE_LAST_X1;
        endcase
    end

    // Rate counter; >= compare lets a mid-run rate reduction wrap at once.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sample_no <= '0;
            in_strobe <= 1'b0;
        end else if (out_strobe) begin
            if (sample_no >= rate_last) begin
                sample_no <= '0;
                in_strobe <= 1'b1;
            end else begin
                sample_no <= sample_no + 16'd1;
                in_strobe <= 1'b0;
            end
        end else begin
            in_strobe <= 1'b0;
        end
    end

    // Comb chain inputs: sign-extended sample into stage 0, then stage to stage.
    always_comb begin
        comb_in[0] = {{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        for (int k = 1; k < STAGES; k++) begin
            comb_in[k] = comb_out[k-1];
        end
    end

    // Low-rate comb stages (M = 1), advanced only when a sample is consumed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_out[k]  <= '0;
                comb_prev[k] <= '0;
            end
        end else if (in_strobe) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_out[k]  <= comb_in[k] - comb_prev[k];
                comb_prev[k] <= comb_in[k];
            end
        end
    end

    // Zero-stuffer: the newest comb output is injected once, zeros otherwise.
    // On a coincident in/out strobe, fresh is still clear, so a zero goes in
    // and the new comb value waits for the following out_strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fresh <= 1'b0;
            stuff <= '0;
        end else begin
            if (out_strobe) begin
                stuff <= fresh ? comb_out[STAGES-1] : '0;
            end
            if (in_strobe) begin
                fresh <= 1'b1;
            end else if (out_strobe) begin
                fresh <= 1'b0;
            end
        end
    end

    // High-rate integrators; wrap-around is harmless because the combs
    // cancel it modulo 2^ACC_WIDTH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
        end else if (out_strobe) begin
            integ[0] <= integ[0] + stuff;
            for (int k = 1; k < STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    assign acc_last = integ[STAGES-1];

    // Pick the output window for the current rate and the bit just below it.
    always_comb begin
        shifted   = acc_last >>> LSB_X1;
        round_bit = acc_last[LSB_X1-1];
        case (rate_sel)
            2'b00: begin
                shifted   = acc_last >>> LSB_X4;
                round_bit = acc_last[LSB_X4-1];
            end
            2'b01: begin
                shifted   = acc_last >>> LSB_X2;
                round_bit = acc_last[LSB_X2-1];
            end
            default: begin
                shifted   = acc_last >>> LSB_X1;
                round_bit = acc_last[LSB_X1-1];
            end
        endcase
    end

    // Round half up, then clamp anything outside the signed output range.
    always_comb begin
        rounded  = {shifted[ACC_WIDTH-1], shifted} + {{ACC_WIDTH{1'b0}}, round_bit};
        out_next = rounded[OUT_WIDTH-1:0];
        if (rounded > OUT_MAX) begin
            out_next = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (rounded < OUT_MIN) begin
            out_next = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end
    end

    // Output register, updated once per high-rate sample.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_data <= '0;
        end else if (out_strobe) begin
            out_data <= out_next;
        end
    end

endmodule

// File: tb/tb_varcic_interp.sv
// tb_varcic_interp: randomized and directed checks of varcic_interp against
// an array-level model of the CIC interpolator (binomial differences of the
// input, zero-stuffing, repeated prefix sums, round/saturate).
module tb_varcic_interp;

  localparam int STAGES        = 5;
  localparam int INTERPOLATION = 320;
  localparam int IN_WIDTH      = 16;
  localparam int ACC_WIDTH     = 58;
  localparam int OUT_WIDTH     = 16;
  localparam int MAX_IN        = 256;

  // ---------------- clock / reset ----------------
  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [1:0]           extra_interpolation;
  logic                 out_strobe;
  logic                 in_strobe;
  logic [IN_WIDTH-1:0]  in_data;
  logic [OUT_WIDTH-1:0] out_data;

  always #5 clock = ~clock;

  varcic_interp #(
    .STAGES(STAGES),
    .INTERPOLATION(INTERPOLATION),
    .IN_WIDTH(IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .extra_interpolation(extra_interpolation),
    .out_strobe(out_strobe),
    .in_strobe(in_strobe),
    .in_data(in_data),
    .out_data(out_data)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  int                   in_vals [MAX_IN];
  logic [OUT_WIDTH-1:0] exp_q[$];
  logic [OUT_WIDTH-1:0] got_q[$];
  int                   istb_strobe_q[$];
  int                   istb_cycle_q[$];
  int                   frozen_err;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rate_of(input logic [1:0] e);
    case (e)
      2'b00:   return INTERPOLATION * 4;
      2'b01:   return INTERPOLATION * 2;
      default: return INTERPOLATION;
    endcase
  endfunction

  function automatic int lsb_of(input logic [1:0] e);
    case (e)
      2'b00:   return ACC_WIDTH - OUT_WIDTH;
      2'b01:   return ACC_WIDTH - OUT_WIDTH - (STAGES - 1);
      default: return ACC_WIDTH - OUT_WIDTH - 2 * (STAGES - 1);
    endcase
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint in_at(input int n);
    if (n < 0 || n >= MAX_IN) return 0;
    return longint'(in_vals[n]);
  endfunction

  // Accumulator wraps at ACC_WIDTH bits, then round half up and clamp.
  function automatic int scale_out(input longint v, input int lsb);
    longint v_acc;
    longint q;
    v_acc = (v <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
    q = (v_acc >>> lsb) + ((v_acc >>> (lsb - 1)) & 64'sd1);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Expected out_data after each of n out_strobes at a fixed rate.
  // Sample m is consumed after out_strobe (m+1)R and injected on the first
  // out_strobe after that cycle; the comb chain delivers the STAGES-th
  // difference of the input delayed by STAGES-1 samples.
  task automatic build_model(input logic [1:0] e, input int gap, input int n);
    int     r;
    int     lsb;
    int     off;
    int     m;
    longint a[];
    longint b[];
    r   = rate_of(e);
    lsb = lsb_of(e);
    off = (gap == 1) ? 2 : 1;
    a = new[n + 1];
    b = new[n + 1];
    for (int j = 0; j <= n; j++) a[j] = 0;
    m = 0;
    while ((m + 1) * r + off <= n) begin
      longint c;
      c = 0;
      for (int i = 0; i <= STAGES; i++)
        c += ((i % 2) ? -64'sd1 : 64'sd1) * binom(STAGES, i) * in_at(m - (STAGES - 1) - i);
      a[(m + 1) * r + off] = c;
      m++;
    end
    for (int p = 0; p < STAGES; p++) begin
      b[0] = 0;
      for (int j = 1; j <= n; j++) b[j] = b[j-1] + a[j-1];
      a = b;
    end
    exp_q.delete();
    for (int j = 1; j <= n; j++) exp_q.push_back(OUT_WIDTH'(scale_out(a[j-1], lsb)));
  endtask

  // ---------------- driver ----------------
  task automatic run_stream(input logic [1:0] e, input int gap, input int n);
    int                   strobes;
    int                   idx;
    int                   cyc;
    logic                 cap_pending;
    logic [OUT_WIDTH-1:0] last_out;
    got_q.delete();
    istb_strobe_q.delete();
    istb_cycle_q.delete();
    frozen_err          = 0;
    extra_interpolation = e;
    out_strobe          = 1'b0;
    reset_n             = 1'b0;
    in_data             = IN_WIDTH'(in_vals[0]);
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_data", $signed(out_data), 0);
    check("reset_in_strobe", in_strobe, 0);
    reset_n     = 1'b1;
    strobes     = 0;
    idx         = 0;
    cyc         = 0;
    cap_pending = 1'b0;
    last_out    = out_data;
    while (strobes < n) begin
      out_strobe = (cyc % gap == 0);
      @(posedge clock);
      #1;
      if (out_strobe) begin
        strobes++;
        got_q.push_back(out_data);
      end else if (out_data !== last_out) begin
        frozen_err++;
      end
      last_out = out_data;
      if (cap_pending) begin
        idx++;
        in_data     = (idx < MAX_IN) ? IN_WIDTH'(in_vals[idx]) : '0;
        cap_pending = 1'b0;
      end
      if (in_strobe) begin
        cap_pending = 1'b1;
        istb_strobe_q.push_back(strobes);
        istb_cycle_q.push_back(cyc);
      end
      cyc++;
    end
    out_strobe = 1'b0;
  endtask

  task automatic score(input string tag, input logic [1:0] e, input int gap, input int n);
    int r;
    int mism;
    int pulse_err;
    int len;
    r         = rate_of(e);
    mism      = 0;
    pulse_err = 0;
    build_model(e, gap, n);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    len = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int j = 0; j < len; j++) if (got_q[j] !== exp_q[j]) mism++;
    check({tag, "_seq_mismatches"}, mism, 0);
    check({tag, "_pulse_count"}, istb_strobe_q.size(), n / r);
    for (int i = 0; i < istb_strobe_q.size(); i++) begin
      if (istb_strobe_q[i] != (i + 1) * r) pulse_err++;
      if (i > 0 && istb_cycle_q[i] - istb_cycle_q[i-1] != gap * r) pulse_err++;
    end
    check({tag, "_pulse_timing"}, pulse_err, 0);
    if (gap > 1) check({tag, "_frozen_between_strobes"}, frozen_err, 0);
  endtask

  function automatic int count_outside(input int lo, input int hi);
    int cnt = 0;
    foreach (got_q[j]) begin
      int v;
      v = int'($signed(got_q[j]));
      if (v < lo || v > hi) cnt++;
    end
    return cnt;
  endfunction

  task automatic fill_const(input int v);
    for (int i = 0; i < MAX_IN; i++) in_vals[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_IN; i++) in_vals[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic rate_switch_test();
    int strobes;
    int waited;
    istb_strobe_q.delete();
    fill_const(10000);
    extra_interpolation = 2'b00;
    out_strobe          = 1'b0;
    reset_n             = 1'b0;
    in_data             = IN_WIDTH'(10000);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    strobes = 0;
    while (strobes < 3461) begin
      if (strobes == 900) extra_interpolation = 2'b10;
      out_strobe = 1'b1;
      @(posedge clock);
      #1;
      strobes++;
      if (in_strobe) istb_strobe_q.push_back(strobes);
    end
    check("switch_first_pulse", (istb_strobe_q.size() > 0) ? istb_strobe_q[0] : -1, 901);
    check("switch_second_pulse", (istb_strobe_q.size() > 1) ? istb_strobe_q[1] : -1, 1221);
    check("pre_reset_out_nonzero", out_data != '0, 1);
    waited = 0;
    while (!in_strobe && waited < 400) begin
      @(posedge clock);
      #1;
      waited++;
    end
    check("pulse_in_flight", in_strobe, 1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("reset_drops_pulse", in_strobe, 0);
    check("reset_clears_out", $signed(out_data), 0);
    out_strobe = 1'b0;
    @(posedge clock);
    #1;
    check("reset_hold_in_strobe", in_strobe, 0);
    reset_n = 1'b1;
  endtask

  // ---------------- timeout ----------------
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   sum;
    int   first_nz;
    int   last_nz;
    logic [1:0] e_rand;

    // DC gain at every rate.
    fill_const(10000);
    run_stream(2'b00, 1, 12800);
    score("dc_x4", 2'b00, 1, 12800);
    check("dc_x4_settled", $signed(got_q[got_q.size()-1]), 6104);
    run_stream(2'b01, 1, 6400);
    score("dc_x2", 2'b01, 1, 6400);
    check("dc_x2_settled", $signed(got_q[got_q.size()-1]), 6104);
    run_stream(2'b10, 1, 3200);
    score("dc_x1", 2'b10, 1, 3200);
    check("dc_x1_settled", $signed(got_q[got_q.size()-1]), 6104);

    // Full scale, both polarities; the step response must not overshoot.
    fill_const(-32768);
    run_stream(2'b10, 1, 3600);
    score("fs_neg", 2'b10, 1, 3600);
    check("fs_neg_settled", $signed(got_q[got_q.size()-1]), -20000);
    check("fs_neg_out_of_range", count_outside(-20000, 0), 0);
    fill_const(32767);
    run_stream(2'b10, 1, 3600);
    score("fs_pos", 2'b10, 1, 3600);
    check("fs_pos_settled", $signed(got_q[got_q.size()-1]), 19999);
    check("fs_pos_out_of_range", count_outside(0, 19999), 0);

    // Impulse: total energy and response span.
    fill_const(0);
    in_vals[0] = 32767;
    run_stream(2'b10, 1, 3600);
    score("impulse", 2'b10, 1, 3600);
    sum      = 0;
    first_nz = -1;
    last_nz  = -1;
    foreach (got_q[j]) begin
      sum += int'($signed(got_q[j]));
      if (got_q[j] != '0) begin
        if (first_nz < 0) first_nz = j;
        last_nz = j;
      end
    end
    check("impulse_sum_close", (sum >= 6399805 - 800) && (sum <= 6399805 + 800), 1);
    check("impulse_span_within", (first_nz >= 0) && (last_nz - first_nz + 1 <= STAGES * INTERPOLATION), 1);

    // Stalled out_strobe (1 in 3) with random data.
    fill_random();
    run_stream(2'b10, 3, 3600);
    score("stall_x1", 2'b10, 3, 3600);

    // Random data with the reserved rate code and a random faster rate.
    fill_random();
    run_stream(2'b11, 1, 3200);
    score("rand_x11", 2'b11, 1, 3200);
    fill_random();
    e_rand = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    run_stream(e_rand, 1, 6400);
    score("rand_fast", e_rand, 1, 6400);

    // Rate reduction mid-period and reset with a pulse in flight.
    rate_switch_test();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
